// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between a UART receiver and its consumer.
// Circular buffer of DEPTH entries with a registered read port (1-cycle latency)
// and a sticky overrun flag for bytes dropped while full.
// Optional macro UART_RX_FIFO_PERR_EN stores the parity error flag with each
// byte; without it entries are 8 bits wide and rd_perr is tied low.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_ready,
  input  logic                     rx_parity_error,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_perr,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_RX_FIFO_PERR_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic          wr_accept;
  logic          rd_accept;
  logic          drop;

`ifdef UART_RX_FIFO_PERR_EN
  assign wr_entry = {rx_parity_error, rx_data};
`else
  logic unused_perr;
  assign unused_perr = rx_parity_error;
  assign wr_entry    = rx_data;
  assign rd_perr     = 1'b0;
`endif

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_entry = mem[rd_ptr];

  // A read frees a slot on the same edge, so a write into a full FIFO is
  // accepted when a read is accepted alongside it.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = rx_data_ready && (!full || rd_accept);
  assign drop      = rx_data_ready && full && !rd_accept;

  // Storage array; contents are not cleared by reset, the pointers make them stale.
  always_ff @(posedge sys_clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  // Registered read port; rd_data holds its last popped value between reads.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_entry[7:0];
      end
    end
  end

`ifdef UART_RX_FIFO_PERR_EN
  // Parity flag popped together with its byte.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_perr <= 1'b0;
    end else if (rd_accept) begin
      rd_perr <= rd_entry[8];
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16) using directed vectors.
// Parity expectations follow whether UART_RX_FIFO_PERR_EN is defined.
module tb_uart_rx_fifo;

  logic       sys_clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_parity_error;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_data_ready   (rx_data_ready),
    .rx_parity_error (rx_parity_error),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_perr         (rd_perr),
    .rd_valid        (rd_valid),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overrun         (overrun),
    .clr_overrun     (clr_overrun)
  );

  // Free-running 10-unit clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    rx_data         = d;
    rx_parity_error = p;
    rx_data_ready   = 1'b1;
    tick();
    rx_data_ready   = 1'b0;
    rx_parity_error = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (rd_perr !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_perr got=%b exp=0", rd_perr); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF;
    for (int i = 0; i < 3; i++) push(vals[i], 1'b0);
    checks++; if (count !== 5'd3) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      pop();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid%0d got=%b exp=1", i, rd_valid); end
      checks++; if (rd_data !== vals[i]) begin failures++; $display("[TB] FAIL basic_data%0d got=%h exp=%h", i, rd_data, vals[i]); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL basic_empty got=%b exp=1", empty); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL basic_end_count got=%0d exp=0", count); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_drop got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("[TB] FAIL basic_hold got=%h exp=ff", rd_data); end
  endtask

  task automatic test_empty_read();
    pop();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("[TB] FAIL empty_rd_hold got=%h exp=ff", rd_data); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL empty_rd_count got=%0d exp=0", count); end
  endtask

  task automatic test_empty_simul();
    rx_data       = 8'h5A;
    rx_data_ready = 1'b1;
    rd_en         = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    rd_en         = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL esimul_valid got=%b exp=0", rd_valid); end
    checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL esimul_count got=%0d exp=1", count); end
    pop();
    checks++; if (rd_data !== 8'h5A) begin failures++; $display("[TB] FAIL esimul_data got=%h exp=5a", rd_data); end
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL esimul_valid2 got=%b exp=1", rd_valid); end
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL fo_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL fo_count got=%0d exp=16", count); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL fo_no_overrun got=%b exp=0", overrun); end
    push(8'h10, 1'b0);
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL fo_overrun got=%b exp=1", overrun); end
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL fo_count2 got=%0d exp=16", count); end
    for (int i = 0; i < 16; i++) begin
      pop();
      checks++; if (rd_data !== 8'(i)) begin failures++; $display("[TB] FAIL fo_data%0d got=%h exp=%h", i, rd_data, 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL fo_empty got=%b exp=1", empty); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL fo_sticky got=%b exp=1", overrun); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL fo_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_clr_set_same();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
    clr_overrun = 1'b1;
    push(8'h99, 1'b0);
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL cs_set_wins got=%b exp=1", overrun); end
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL cs_count got=%0d exp=16", count); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL cs_clear got=%b exp=0", overrun); end
    for (int i = 0; i < 16; i++) begin
      pop();
      checks++; if (rd_data !== 8'(8'h20 + i)) begin failures++; $display("[TB] FAIL cs_data%0d got=%h exp=%h", i, rd_data, 8'(8'h20 + i)); end
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    rx_data       = 8'h77;
    rx_data_ready = 1'b1;
    rd_en         = 1'b1;
    tick();
    rx_data_ready = 1'b0;
    rd_en         = 1'b0;
    checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL fs_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL fs_full got=%b exp=1", full); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL fs_overrun got=%b exp=0", overrun); end
    checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL fs_first got=%h/%b exp=00/1", rd_data, rd_valid); end
    for (int i = 1; i < 17; i++) begin
      pop();
      if (i < 16) begin
        checks++; if (rd_data !== 8'(i)) begin failures++; $display("[TB] FAIL fs_data%0d got=%h exp=%h", i, rd_data, 8'(i)); end
      end else begin
        checks++; if (rd_data !== 8'h77) begin failures++; $display("[TB] FAIL fs_last got=%h exp=77", rd_data); end
      end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL fs_empty got=%b exp=1", empty); end
  endtask

  task automatic test_parity();
    logic exp_p;
`ifdef UART_RX_FIFO_PERR_EN
    exp_p = 1'b1;
`else
    exp_p = 1'b0;
`endif
    push(8'h81, 1'b1);
    push(8'h02, 1'b0);
    pop();
    checks++; if (rd_data !== 8'h81) begin failures++; $display("[TB] FAIL perr_data0 got=%h exp=81", rd_data); end
    checks++; if (rd_perr !== exp_p) begin failures++; $display("[TB] FAIL perr_flag0 got=%b exp=%b", rd_perr, exp_p); end
    pop();
    checks++; if (rd_data !== 8'h02) begin failures++; $display("[TB] FAIL perr_data1 got=%h exp=02", rd_data); end
    checks++; if (rd_perr !== 1'b0) begin failures++; $display("[TB] FAIL perr_flag1 got=%b exp=0", rd_perr); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'b0);
    push(8'hEE, 1'b0);
    for (int i = 0; i < 11; i++) pop();
    checks++; if (count !== 5'd5 || overrun !== 1'b1) begin failures++; $display("[TB] FAIL rm_pre got=%0d/%b exp=5/1", count, overrun); end
    reset         = 1'b1;
    rx_data       = 8'hEE;
    rx_data_ready = 1'b1;
    clr_overrun   = 1'b1;
    rd_en         = 1'b1;
    tick();
    reset         = 1'b0;
    rx_data_ready = 1'b0;
    clr_overrun   = 1'b0;
    rd_en         = 1'b0;
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL rm_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL rm_empty got=%b exp=1", empty); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL rm_overrun got=%b exp=0", overrun); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("[TB] FAIL rm_rdport got=%b/%h exp=0/00", rd_valid, rd_data); end
    push(8'hC3, 1'b0);
    pop();
    checks++; if (rd_data !== 8'hC3 || rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rm_after got=%h/%b exp=c3/1", rd_data, rd_valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL rm_end_empty got=%b exp=1", empty); end
  endtask

  // Test sequence.
  initial begin
    reset           = 1'b1;
    rx_data         = 8'h00;
    rx_data_ready   = 1'b0;
    rx_parity_error = 1'b0;
    rd_en           = 1'b0;
    clr_overrun     = 1'b0;
    test_reset();
    test_basic();
    test_empty_read();
    test_empty_simul();
    test_full_overrun();
    test_clr_set_same();
    test_full_simul();
    test_parity();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of 8-bit entries; SHALL be a power of two, minimum 2.
REQ-002 Ports SHALL be, in order (clock and reset first):
- sys_clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_data_ready  in  1  one-cycle strobe; rx_data (and rx_parity_error) valid this cycle.
- rx_parity_error  in  1  parity error flag for the byte strobed this cycle.
- rd_en  in  1  consumer read request.
- rd_data  out  8  byte popped by the last accepted read.
- rd_perr  out  1  parity flag popped with rd_data.
- rd_valid  out  1  one-cycle strobe; rd_data/rd_perr updated this cycle.
- empty  out  1  high when count == 0.
- full  out  1  high when count == DEPTH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overrun  out  1  sticky; set when a byte was dropped.
- clr_overrun  in  1  clears overrun.
REQ-003 Clock port SHALL be named sys_clk and reset port SHALL be named reset; reset is synchronous and active-high.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH entries, each {perr, data[7:0]}, with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-005 Write accept: rx_data_ready=1 and (full=0 or read accepted in the same cycle) -> entry stored at wr_ptr, wr_ptr increments.
REQ-006 Read accept: rd_en=1 and empty=0 -> entry at rd_ptr copied to rd_data/rd_perr on the same edge, rd_ptr increments, rd_valid=1 for the following cycle (registered read latency of 1 cycle).
REQ-007 rd_en while empty SHALL be ignored: no pointer change, rd_valid=0, rd_data/rd_perr hold.
REQ-008 Simultaneous write and read while empty: write accepted, read ignored, count becomes 1.
REQ-009 Simultaneous write and read while full: both accepted, count stays DEPTH, full stays 1, overrun not set.
REQ-010 rx_data_ready while full with no accepted read: byte dropped, pointers unchanged, overrun set to 1 on that edge.
REQ-011 count SHALL update on the same edge as the pointers: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-012 empty and full SHALL be derived combinationally from count.
REQ-013 overrun SHALL hold until clr_overrun=1; if clr_overrun and a new overrun occur in the same cycle, overrun SHALL remain 1 (set wins).
REQ-014 rd_data and rd_perr SHALL hold their last popped value between reads.

Reset
REQ-015 On sys_clk edge with reset=1: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, rd_valid=0, rd_data=8'h00, rd_perr=0.
REQ-016 Reset SHALL take priority over any simultaneous write, read, or clr_overrun; storage contents need not be cleared.
REQ-017 Reset asserted mid-operation SHALL discard all stored bytes; the first write after reset deassertion lands at entry 0.

Configuration
REQ-018 Macro UART_RX_FIFO_PERR_EN defined: each entry stores rx_parity_error alongside data and rd_perr reflects the stored flag.
REQ-019 Macro UART_RX_FIFO_PERR_EN undefined: parity flag not stored (entries 8 bits), rx_parity_error ignored, rd_perr tied to 0; all other behaviour identical.

Verification (DEPTH=16, UART_RX_FIFO_PERR_EN defined unless noted)
REQ-020 Reset, then write 8'hA5, 8'h3C, 8'hFF; read three times -> rd_data A5, 3C, FF each one cycle after rd_en with rd_valid=1; empty=1, count=0 at end.
REQ-021 Write 16 bytes 8'h00..8'h0F -> full=1, count=16; 17th write 8'h10 -> overrun=1, count=16; 16 reads return 00..0F, 8'h10 never appears.
REQ-022 Full FIFO, rx_data_ready and rd_en in the same cycle with 8'h77 -> count stays 16, overrun=0; 16 further reads end with 8'h77.
REQ-023 Empty FIFO, rd_en and rx_data_ready(8'h5A) together -> rd_valid=0, count=1; next read returns 5A.
REQ-024 Write 8'h81 with rx_parity_error=1, then 8'h02 with 0 -> rd_perr 1 then 0; rebuilt without UART_RX_FIFO_PERR_EN -> rd_perr=0 both times.
REQ-025 Hold 5 bytes, assert reset for one cycle alongside rx_data_ready, overrun set and clr_overrun=1 -> count=0, empty=1, overrun=0; next write 8'hC3 then read returns C3.
